// File: rtl/memory_responder.sv
// memory_responder: four-phase request/acknowledge responder around a
// single-port word-addressed storage array.
// Latency: a request sampled in IDLE completes WAIT_CYCLES+1 cycles later
// (MemReady rises then); MemReady is held until Read and Write both drop.
// Backpressure: the requester holds Read/Write until MemReady, then releases;
// inputs are ignored while an access is in flight.
//
// Ports:
//   clock_i      sole clock, rising edge
//   clear_n_i    asynchronous active-low clear (storage array is not cleared)
//   read_i       read request level
//   write_i      write request level
//   address_i    word address (from MAR)
//   datain_i     write data (from MDR)
//   mdatain_o    read data (to MDR Mdatain), holds last read value
//   mem_ready_o  access complete, high only in DONE
//   mem_err_o    one-cycle pulse when Read and Write are both requested
module memory_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2   // legal range 0..15
) (
  input  logic                  clock_i,
  input  logic                  clear_n_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] datain_i,
  output logic [DATA_WIDTH-1:0] mdatain_o,
  output logic                  mem_ready_o,
  output logic                  mem_err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // The wait counter is 4 bits wide, which bounds WAIT_CYCLES to 15.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    is_wr_q;
  logic [DATA_WIDTH-1:0]   mdatain_q;
  logic                    ready_q;
  logic                    err_q;

  // Storage array: deliberately has no reset so contents survive Clear.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // The access edge is the last BUSY cycle (counter already at zero).
  logic                    access_now;
  logic                    mem_we;

  assign access_now = (state_q == BUSY) && (cnt_q == 4'd0);
  // While Clear is low the FSM is held in IDLE, so an aborted write can
  // never reach the array.
  assign mem_we     = access_now && is_wr_q;

  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  // Control FSM; all outputs are registered here.
  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      is_wr_q   <= 1'b0;
      mdatain_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Error is a single-cycle pulse: cleared unless re-raised below.
      err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (read_i && write_i) begin
            // Ambiguous request: refuse it, flag it, stay put.
            err_q <= 1'b1;
          end else if (read_i || write_i) begin
            addr_q  <= address_i;
            data_q  <= datain_i;
            is_wr_q <= write_i;
            cnt_q   <= WAIT_LOAD;
            state_q <= BUSY;
          end
        end

        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Writes land in the array via mem_we; only reads touch mdatain.
            if (!is_wr_q) begin
              mdatain_q <= mem_q[addr_q];
            end
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          // Four-phase release: hold ready until the request is withdrawn.
          if (!read_i && !write_i) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mdatain_o   = mdatain_q;
  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench for memory_responder.
// Two instances: index 0 with two wait states, index 1 with zero wait states.
// Read expectations are queued when a read is driven and popped at MemReady.
module tb_memory_responder;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          rd   [2];
  logic          wr   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];
  logic [DW-1:0] dout [2];
  logic          rdy  [2];
  logic          err  [2];

  logic [DW-1:0] model   [2][512];
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] exp_q   [$];

  int n_chk;
  int n_bad;

  always #5 clk = ~clk;

  memory_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(W0)
  ) u_dut0 (
    .clock_i    (clk),
    .clear_n_i  (clear_n),
    .read_i     (rd[0]),
    .write_i    (wr[0]),
    .address_i  (addr[0]),
    .datain_i   (din[0]),
    .mdatain_o  (dout[0]),
    .mem_ready_o(rdy[0]),
    .mem_err_o  (err[0])
  );

  memory_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(W1)
  ) u_dut1 (
    .clock_i    (clk),
    .clear_n_i  (clear_n),
    .read_i     (rd[1]),
    .write_i    (wr[1]),
    .address_i  (addr[1]),
    .datain_i   (din[1]),
    .mdatain_o  (dout[1]),
    .mem_ready_o(rdy[1]),
    .mem_err_o  (err[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  // One full four-phase access. hold = extra cycles the request stays high
  // after MemReady; scramble = churn Address/Datain while the access is busy.
  task automatic access(input int d, input bit is_wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] v, input int hold, input bit scramble);
    int            lat;
    bit            err_seen;
    logic [DW-1:0] e;
    @(negedge clk);
    rd[d]   = !is_wr;
    wr[d]   = is_wr;
    addr[d] = a;
    din[d]  = v;
    if (is_wr) model[d][a] = v;
    else       exp_q.push_back(model[d][a]);
    @(posedge clk); #1;
    check_val("ready_low_after_sample", 32'(rdy[d]), 32'd0);
    err_seen = err[d];
    if (scramble) begin
      addr[d] = a + 9'd1;
      din[d]  = $urandom;
    end
    lat = 0;
    while (!rdy[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      err_seen |= err[d];
      if (scramble && !rdy[d]) begin
        addr[d] = addr[d] + 9'd1;
        din[d]  = $urandom;
      end
    end
    check_val("latency", 32'(lat), 32'(wait_of(d) + 1));
    check_val("no_err_during_access", 32'(err_seen), 32'd0);
    if (!is_wr) begin
      check_val("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
      check_val("read_data", dout[d], e);
      last_rd[d] = e;
    end else begin
      check_val("write_keeps_mdatain", dout[d], last_rd[d]);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_val("ready_held", 32'(rdy[d]), 32'd1);
      check_val("mdatain_held", dout[d], last_rd[d]);
    end
    @(negedge clk);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    @(posedge clk); #1;
    check_val("ready_drops_on_release", 32'(rdy[d]), 32'd0);
  endtask

  task automatic illegal(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    rd[d]   = 1'b1;
    wr[d]   = 1'b1;
    addr[d] = a;
    din[d]  = v;
    @(posedge clk); #1;
    check_val("err_pulse", 32'(err[d]), 32'd1);
    check_val("err_no_ready", 32'(rdy[d]), 32'd0);
    @(negedge clk);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    @(posedge clk); #1;
    check_val("err_one_cycle", 32'(err[d]), 32'd0);
    check_val("err_still_no_ready", 32'(rdy[d]), 32'd0);
    check_val("err_keeps_mdatain", dout[d], last_rd[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    clear_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d]      = 1'b0;
      wr[d]      = 1'b0;
      addr[d]    = '0;
      din[d]     = '0;
      last_rd[d] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val("reset_mdatain", dout[d], 32'd0);
      check_val("reset_ready", 32'(rdy[d]), 32'd0);
      check_val("reset_err", 32'(err[d]), 32'd0);
    end
    @(negedge clk);
    clear_n = 1'b1;

    // Write then read back
    access(0, 1'b1, 9'h010, 32'hDEADBEEF, 0, 1'b0);
    access(0, 1'b0, 9'h010, 32'h0,        0, 1'b0);

    // Inputs ignored while busy
    access(0, 1'b1, 9'h005, 32'h11112222, 0, 1'b0);
    access(0, 1'b1, 9'h006, 32'h33334444, 0, 1'b0);
    access(0, 1'b0, 9'h005, 32'h0,        0, 1'b1);

    // Illegal request leaves storage and Mdatain alone
    access(0, 1'b1, 9'h020, 32'hA5A5A5A5, 0, 1'b0);
    illegal(0, 9'h020, 32'h0BADC0DE);
    access(0, 1'b0, 9'h020, 32'h0,        0, 1'b0);

    // Mid-access reset aborts the write
    access(0, 1'b1, 9'h1FF, 32'hCAFEF00D, 0, 1'b0);
    @(negedge clk);
    wr[0]   = 1'b1;
    addr[0] = 9'h1FF;
    din[0]  = 32'h12345678;
    @(posedge clk);   // request sampled
    @(posedge clk);   // second BUSY cycle begins
    #2;
    clear_n = 1'b0;
    #1;
    check_val("abort_mdatain_zero", dout[0], 32'd0);
    check_val("abort_ready_zero", 32'(rdy[0]), 32'd0);
    check_val("abort_err_zero", 32'(err[0]), 32'd0);
    wr[0] = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    clear_n = 1'b1;
    access(0, 1'b0, 9'h1FF, 32'h0, 0, 1'b0);

    // Zero wait states, request held past MemReady
    access(1, 1'b1, 9'h033, 32'h89ABCDEF, 0, 1'b0);
    access(1, 1'b0, 9'h033, 32'h0,        4, 1'b0);

    // Back-to-back traffic on both instances
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        access(d, 1'b1, 9'(i * 37 + 64), $urandom, 0, 1'b0);
      end
    end
    for (int i = 5; i >= 0; i--) begin
      for (int d = 0; d < 2; d++) begin
        access(d, 1'b0, 9'(i * 37 + 64), 32'h0, (i == 2) ? 1 : 0, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
